// File: rtl/tile_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tile_renderer
// Function : Walks a tile map and paints each tile as a square of pixels into
//            a frame buffer, pausing whenever the display is active.
// Revision : 1.0
// ============================================================================
module tile_renderer #(
    parameter int          BLOCK_SIZE   = 8,
    parameter int          MAPA_WIDTH   = 80,
    parameter int          MAPA_HEIGHT  = 60,
    parameter int          READ_LATENCY = 1,
    parameter int          GRID_EN      = 0,
    parameter logic [5:0]  COR_FRUTA    = 6'b110000,
    parameter logic [5:0]  COR_OBST     = 6'b111111,
    parameter logic [5:0]  COR_COBRA1   = 6'b001100,
    parameter logic [5:0]  COR_COBRA2   = 6'b001111,
    parameter logic [5:0]  COR_CABECA   = 6'b111100,
    parameter logic [5:0]  COR_GRID     = 6'b010101,
    parameter logic [5:0]  COR_FUNDO    = 6'b000000
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    input  logic                                           vga_active,
    input  logic [3:0]                                     mapa_block,
    output logic [$clog2(MAPA_WIDTH)-1:0]                  mapa_x,
    output logic [$clog2(MAPA_HEIGHT)-1:0]                 mapa_y,
    output logic                                           mapa_read,
    input  logic                                           buffer_ready,
    output logic [5:0]                                     buffer_cor,
    output logic [$clog2(MAPA_WIDTH*BLOCK_SIZE)-1:0]       buffer_x,
    output logic [$clog2(MAPA_HEIGHT*BLOCK_SIZE)-1:0]      buffer_y,
    output logic                                           buffer_write,
    output logic                                           busy,
    output logic                                           frame_done
);

    localparam int c_MXW = $clog2(MAPA_WIDTH);
    localparam int c_MYW = $clog2(MAPA_HEIGHT);
    localparam int c_XW  = $clog2(MAPA_WIDTH * BLOCK_SIZE);
    localparam int c_YW  = $clog2(MAPA_HEIGHT * BLOCK_SIZE);
    localparam int c_PW  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int c_LW  = $clog2(READ_LATENCY + 1);

    localparam logic [c_MXW-1:0] c_MX_LAST  = c_MXW'(MAPA_WIDTH - 1);
    localparam logic [c_MYW-1:0] c_MY_LAST  = c_MYW'(MAPA_HEIGHT - 1);
    localparam logic [c_PW-1:0]  c_PX_LAST  = c_PW'(BLOCK_SIZE - 1);
    localparam logic [c_LW-1:0]  c_LAT_LAST = c_LW'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_PAINT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q;
    logic [c_MXW-1:0]  mx_q;
    logic [c_MYW-1:0]  my_q;
    logic [c_PW-1:0]   px_q;
    logic [c_PW-1:0]   py_q;
    logic [c_LW-1:0]   lat_q;
    logic [3:0]        code_q;
    logic              busy_q;
    logic              done_q;

    logic              xfer;
    logic              px_last;
    logic              py_last;
    logic [5:0]        cor_dec;
    logic              is_fundo;

    assign mapa_read    = (state_q == S_FETCH) && !vga_active;
    assign buffer_write = (state_q == S_PAINT) && !vga_active;
    assign xfer         = buffer_write && buffer_ready;
    assign px_last      = (px_q == c_PX_LAST);
    assign py_last      = (py_q == c_PX_LAST);

    // Head (1x00) takes priority over the generic body codes 10xx / 11xx.
    always_comb begin
        cor_dec  = COR_FUNDO;
        is_fundo = 1'b0;
        if (code_q[3] && (code_q[1:0] == 2'b00)) begin
            cor_dec = COR_CABECA;
        end else if (code_q[3:2] == 2'b10) begin
            cor_dec = COR_COBRA1;
        end else if (code_q[3:2] == 2'b11) begin
            cor_dec = COR_COBRA2;
        end else if (code_q == 4'b0001) begin
            cor_dec = COR_FRUTA;
        end else if (code_q == 4'b0010) begin
            cor_dec = COR_OBST;
        end else begin
            is_fundo = 1'b1;
        end
        if ((GRID_EN != 0) && is_fundo && ((px_q == '0) || (py_q == '0))) begin
            cor_dec = COR_GRID;
        end
    end

    assign buffer_cor = (state_q == S_PAINT) ? cor_dec : 6'b000000;
    assign buffer_x   = c_XW'(mx_q) * c_XW'(BLOCK_SIZE) + c_XW'(px_q);
    assign buffer_y   = c_YW'(my_q) * c_YW'(BLOCK_SIZE) + c_YW'(py_q);
    assign mapa_x     = mx_q;
    assign mapa_y     = my_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mx_q    <= '0;
            my_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            lat_q   <= '0;
            code_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        mx_q    <= '0;
                        my_q    <= '0;
                        px_q    <= '0;
                        py_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (!vga_active) begin
                        state_q <= S_WAIT;
                        lat_q   <= '0;
                    end
                end
                // Latency count runs regardless of vga_active: the memory answers anyway.
                S_WAIT: begin
                    if (lat_q == c_LAT_LAST) begin
                        code_q  <= mapa_block;
                        lat_q   <= '0;
                        state_q <= S_PAINT;
                    end else begin
                        lat_q <= lat_q + c_LW'(1);
                    end
                end
                S_PAINT: begin
                    if (xfer) begin
                        if (!px_last) begin
                            px_q <= px_q + c_PW'(1);
                        end else begin
                            px_q <= '0;
                            if (!py_last) begin
                                py_q <= py_q + c_PW'(1);
                            end else begin
                                py_q <= '0;
                                if (mx_q != c_MX_LAST) begin
                                    mx_q    <= mx_q + c_MXW'(1);
                                    state_q <= S_FETCH;
                                end else if (my_q != c_MY_LAST) begin
                                    mx_q    <= '0;
                                    my_q    <= my_q + c_MYW'(1);
                                    state_q <= S_FETCH;
                                end else begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    mx_q    <= '0;
                    my_q    <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
